// File: rtl/imem_program_encoder_if.sv
// rtl/imem_program_encoder_if.sv - instruction-field stream in, instruction-memory write port out
interface imem_program_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_encoder.sv
// rtl/imem_program_encoder.sv - packs symbolic MIPS instructions into words and loads them into imem
module imem_program_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_program_encoder_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SLT  = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_J    = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [31:0]       HALT_WORD = 32'hFC00_0000;
    localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       enc_word;
    logic              fire;
    logic              is_halt;
    logic              at_last;

    assign bus.in_ready   = (state == S_LOAD);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    assign fire    = bus.in_valid && (state == S_LOAD);
    assign is_halt = (bus.in_op == OP_HALT);
    assign at_last = (ptr == LAST_PTR);

    // Only the fields an op actually uses are placed into its word.
    always_comb begin
        enc_word = HALT_WORD;
        case (bus.in_op)
            OP_ADD:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h20};
            OP_SLT:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h2a};
            OP_BEQ:  enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_LW:   enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_SW:   enc_word = {6'h2b, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_ADDI: enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            OP_J:    enc_word = {6'h02, bus.in_target};
            default: enc_word = HALT_WORD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            count   <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (fire) begin
                        we_q   <= 1'b1;
                        addr_q <= ptr;
                        count  <= count + (ADDR_W+1)'(1);
                        // The last slot is reserved for a halt so the program always terminates.
                        if (is_halt || at_last) begin
                            wdata_q <= HALT_WORD;
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            error   <= !is_halt;
                        end else begin
                            wdata_q <= enc_word;
                            ptr     <= ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        ptr   <= '0;
                        count <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
